sram_init_wrapper: RTL

- Parametrised single-port synchronous SRAM wrapper with a valid/ready request port, per-byte write mask and a registered read response with a valid flag.
- After every reset, a built-in sweep state machine writes INIT_VALUE to every word, so contents are defined before use.
- Sits between the core's load/store or fetch logic and the raw storage array; it is the general replacement for the fixed-width, unmasked, no-handshake RAM wrapper.

---
 rtl/sram_init_wrapper.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sram_init_wrapper.sv
// sram_init_wrapper
//   Single-port synchronous SRAM wrapper with a valid/ready request port,
//   per-byte write mask and a registered read response. After every reset a
//   sweep state machine writes INIT_VALUE to every word before requests are
//   accepted.
//
// Parameters:
//   ADDR_WIDTH  word address width, depth = 2**ADDR_WIDTH
//   DATA_WIDTH  word width in bits (multiple of 8)
//   INIT_VALUE  value written to every word by the init sweep
//   MASK_WIDTH  (derived, DATA_WIDTH/8) byte-lane count
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  wrapper accepts a request this cycle (high once init is done)
//   req_write  1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_wmask  byte enables, bit i covers bits [8i+7:8i]
//   rsp_valid  one-cycle pulse per read, rsp_data valid
//   rsp_data   read data, holds last value while rsp_valid is low
//   init_done  high once the init sweep has completed
//
// Build option:
//   SRAM_OUT_REG_EN  adds an output register stage (read latency 2)
module sram_init_wrapper #(
    parameter int unsigned            ADDR_WIDTH = 8,
    parameter int unsigned            DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wmask,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      init_done
);

    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   cnt_next;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [MASK_WIDTH-1:0]   mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    rd_en;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state, handshake and write-port steering
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        init_done  = 1'b0;
        mem_we     = '0;
        mem_waddr  = req_addr;
        mem_wdata  = req_wdata;
        rd_en      = 1'b0;

        case (state)
            ST_INIT: begin
                // Sweep owns the write port; request inputs are ignored.
                mem_we    = '1;
                mem_waddr = cnt;
                mem_wdata = INIT_VALUE;
                cnt_next  = cnt + 1'b1;
                if (cnt == '1) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
                if (req_valid) begin
                    if (req_write) begin
                        mem_we = req_wmask;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase

        // A request coinciding with reset is dropped entirely.
        if (rst) begin
            mem_we = '0;
            rd_en  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Storage array: one byte-masked write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
            if (mem_we[i]) begin
                mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port and response register(s)
    // ------------------------------------------------------------------
`ifdef SRAM_OUT_REG_EN
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            s1_valid  <= rd_en;
            if (rd_en) begin
                s1_data <= mem[req_addr];
            end
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_data <= s1_data;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd_en;
            if (rd_en) begin
                rsp_data <= mem[req_addr];
            end
        end
    end
`endif

endmodule
